// File: rtl/sos_pkg.sv
// sos_pkg: shared types and constants for the speed-of-sound ranging path
package sos_pkg;
  localparam int SAMPLE_W = 16;
  localparam int SAMPLE_RATE = 24000;
  typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_EMIT, ST_GUARD} probe_state_e;
endpackage

// File: rtl/probe_burst_tx_if.sv
// probe_burst_tx_if: sample strobe/control inputs and sample/status outputs of the probe transmitter
interface probe_burst_tx_if;
  import sos_pkg::*;
  logic step_in;
  logic start_in;
  logic abort_in;
  logic signed [SAMPLE_W-1:0] amp_out;
  logic onset_out;
  logic busy_out;
  logic done_out;
  modport slave (input step_in, start_in, abort_in, output amp_out, onset_out, busy_out, done_out);
  modport master (output step_in, start_in, abort_in, input amp_out, onset_out, busy_out, done_out);
endinterface

// File: rtl/probe_envelope_gain.sv
// probe_envelope_gain: registered signed burst sample with linear attack/decay envelope
module probe_envelope_gain
  import sos_pkg::*;
#(
  parameter int N = 24,
  parameter int AMPLITUDE = 16000,
  parameter int RAMP_LOG2 = 2,
  parameter int IW = $clog2(N) + 1
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic ld_i,
  input  logic clr_i,
  input  logic [IW-1:0] idx_i,
  input  logic neg_i,
  output logic signed [SAMPLE_W-1:0] sample_o
);
  localparam int PW = SAMPLE_W + RAMP_LOG2;
  localparam int RAMP = 1 << RAMP_LOG2;
  int env;
  logic [PW-1:0] prod;
  logic [SAMPLE_W-1:0] mag;
  logic signed [SAMPLE_W-1:0] sample_q;
  // envelope is min(i+1, RAMP, N-i); product kept unsigned and wide before the shift
  always_comb begin
    env = int'(idx_i) + 1;
    env = env < RAMP ? env : RAMP;
    env = env < N - int'(idx_i) ? env : N - int'(idx_i);
    prod = PW'(AMPLITUDE) * PW'(env);
    mag = SAMPLE_W'(prod >> RAMP_LOG2);
  end
  // sample register: cleared on reset/abort/burst end, loaded on an emitting strobe
  always_ff @(posedge clk_in)
    if (!rst_in || clr_i) sample_q <= '0;
    else if (ld_i) sample_q <= neg_i ? -$signed(mag) : $signed(mag);
  assign sample_o = sample_q;
endmodule

// File: rtl/probe_burst_tx.sv
// probe_burst_tx: square-wave probe burst with onset marker and guard interval; PROBE_RAMP_EN enables the envelope
module probe_burst_tx
  import sos_pkg::*;
#(
  parameter int HALF_PERIOD = 3,
  parameter int CYCLES = 4,
  parameter int AMPLITUDE = 16000,
  parameter int RAMP_LOG2 = 2,
  parameter int GUARD = 256
) (
  input logic clk_in,
  input logic rst_in,
  probe_burst_tx_if.slave bus
);
  localparam int N = 2 * HALF_PERIOD * CYCLES;
  localparam int IW = $clog2(N) + 1;
  localparam int HW = $clog2(HALF_PERIOD) + 1;
  localparam int GW = $clog2(GUARD) + 1;
  probe_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [HW-1:0] half_q, half_d;
  logic [GW-1:0] gcnt_q, gcnt_d;
  logic neg_q, neg_d, onset_q, onset_d, busy_q, busy_d, done_q, done_d;
  logic load, clear;
  logic signed [SAMPLE_W-1:0] amp;
  // next state: idx/half/neg describe the next sample to emit; abort outranks step
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    half_d = half_q;
    neg_d = neg_q;
    gcnt_d = gcnt_q;
    busy_d = busy_q;
    onset_d = 1'b0;
    done_d = 1'b0;
    load = 1'b0;
    clear = 1'b0;
    if (state_q == ST_IDLE) begin
      if (bus.start_in) begin
        state_d = ST_ARMED;
        busy_d = 1'b1;
        idx_d = '0;
        half_d = '0;
        neg_d = 1'b0;
        gcnt_d = '0;
      end
    end else if (bus.abort_in) begin
      state_d = ST_IDLE;
      busy_d = 1'b0;
      clear = 1'b1;
    end else if (bus.step_in) begin
      if (state_q == ST_GUARD) begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q == GW'(GUARD - 1)) begin
          state_d = ST_IDLE;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end else if (idx_q == IW'(N)) begin
        state_d = ST_GUARD;
        gcnt_d = '0;
        clear = 1'b1;
      end else begin
        state_d = ST_EMIT;
        onset_d = state_q == ST_ARMED;
        load = 1'b1;
        idx_d = idx_q + 1'b1;
        half_d = half_q == HW'(HALF_PERIOD - 1) ? '0 : half_q + 1'b1;
        neg_d = neg_q ^ (half_q == HW'(HALF_PERIOD - 1));
      end
    end
  end
  // state and status registers
  always_ff @(posedge clk_in)
    if (!rst_in) begin
      state_q <= ST_IDLE;
      idx_q <= '0;
      half_q <= '0;
      gcnt_q <= '0;
      neg_q <= 1'b0;
      onset_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      half_q <= half_d;
      gcnt_q <= gcnt_d;
      neg_q <= neg_d;
      onset_q <= onset_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
`ifdef PROBE_RAMP_EN
  probe_envelope_gain #(.N(N), .AMPLITUDE(AMPLITUDE), .RAMP_LOG2(RAMP_LOG2), .IW(IW)) u_gain (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .ld_i(load),
    .clr_i(clear),
    .idx_i(idx_q),
    .neg_i(neg_q),
    .sample_o(amp)
  );
`else
  localparam logic [SAMPLE_W-1:0] MAG = SAMPLE_W'((AMPLITUDE << RAMP_LOG2) >> RAMP_LOG2);
  logic signed [SAMPLE_W-1:0] amp_q;
  // constant-magnitude sample register with the same load/clear timing as the envelope path
  always_ff @(posedge clk_in)
    if (!rst_in || clear) amp_q <= '0;
    else if (load) amp_q <= neg_q ? -$signed(MAG) : $signed(MAG);
  assign amp = amp_q;
`endif
  assign bus.amp_out = amp;
  assign bus.onset_out = onset_q;
  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
endmodule

// File: tb/tb_probe_burst_tx.sv
// tb_probe_burst_tx: directed checks of burst shape, onset, guard, abort and reset
module tb_probe_burst_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
`ifdef PROBE_RAMP_EN
  int exp_amp [12] = '{4000, 8000, 8000, -8000, -8000, -8000, 8000, 8000, 8000, -8000, -8000, -4000};
`else
  int exp_amp [12] = '{8000, 8000, 8000, -8000, -8000, -8000, 8000, 8000, 8000, -8000, -8000, -8000};
`endif
  probe_burst_tx_if bus ();
  probe_burst_tx #(.HALF_PERIOD(3), .CYCLES(2), .AMPLITUDE(8000), .RAMP_LOG2(1), .GUARD(4)) dut (
    .clk_in(clk),
    .rst_in(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic outs(input string tag, input int amp, input int onset, input int busy, input int done);
    chk({tag, ".amp"}, bus.amp_out, amp);
    chk({tag, ".onset"}, bus.onset_out, onset);
    chk({tag, ".busy"}, bus.busy_out, busy);
    chk({tag, ".done"}, bus.done_out, done);
  endtask
  task automatic strobe();
    bus.step_in = 1'b1;
    cyc();
    bus.step_in = 1'b0;
  endtask
  initial begin
    bus.step_in = 1'b0;
    bus.start_in = 1'b0;
    bus.abort_in = 1'b0;
    repeat (2) cyc();
    outs("reset", 0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) cyc();
    outs("idle", 0, 0, 0, 0);
    bus.abort_in = 1'b1;
    cyc();
    bus.abort_in = 1'b0;
    outs("idle_abort", 0, 0, 0, 0);
    bus.start_in = 1'b1;
    bus.step_in = 1'b1;
    cyc();
    bus.start_in = 1'b0;
    bus.step_in = 1'b0;
    outs("start_step", 0, 0, 1, 0);
    repeat (9) cyc();
    for (int i = 0; i < 12; i++) begin
      strobe();
      outs($sformatf("burst%0d", i), exp_amp[i], i == 0 ? 1 : 0, 1, 0);
      cyc();
      outs($sformatf("hold%0d", i), exp_amp[i], 0, 1, 0);
      if (i == 4 || i == 8) bus.start_in = 1'b1;
      repeat (4) cyc();
      bus.start_in = 1'b0;
      repeat (4) cyc();
    end
    strobe();
    outs("burst_end", 0, 0, 1, 0);
    repeat (9) cyc();
    for (int g = 1; g <= 4; g++) begin
      strobe();
      outs($sformatf("guard%0d", g), 0, 0, g == 4 ? 0 : 1, g == 4 ? 1 : 0);
      if (g == 4) break;
      bus.start_in = g == 2;
      repeat (4) cyc();
      bus.start_in = 1'b0;
      repeat (5) cyc();
    end
    bus.start_in = 1'b1;
    cyc();
    bus.start_in = 1'b0;
    outs("restart", 0, 0, 1, 0);
    repeat (9) cyc();
    for (int i = 0; i < 6; i++) begin
      strobe();
      outs($sformatf("pre_abort%0d", i), exp_amp[i], i == 0 ? 1 : 0, 1, 0);
      repeat (9) cyc();
    end
    bus.abort_in = 1'b1;
    bus.step_in = 1'b1;
    cyc();
    bus.abort_in = 1'b0;
    bus.step_in = 1'b0;
    outs("abort", 0, 0, 0, 0);
    repeat (9) cyc();
    for (int k = 0; k < 6; k++) begin
      strobe();
      outs($sformatf("post_abort%0d", k), 0, 0, 0, 0);
      repeat (9) cyc();
    end
    bus.start_in = 1'b1;
    bus.abort_in = 1'b1;
    cyc();
    bus.start_in = 1'b0;
    bus.abort_in = 1'b0;
    outs("start_abort", 0, 0, 1, 0);
    repeat (9) cyc();
    for (int i = 0; i < 4; i++) begin
      strobe();
      outs($sformatf("fresh%0d", i), exp_amp[i], i == 0 ? 1 : 0, 1, 0);
      repeat (9) cyc();
    end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    outs("mid_reset", 0, 0, 0, 0);
    repeat (9) cyc();
    for (int k = 0; k < 3; k++) begin
      strobe();
      outs($sformatf("post_reset%0d", k), 0, 0, 0, 0);
      repeat (9) cyc();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/probe_burst_tx.md
# probe_burst_tx

Transmit side of the speed-of-sound ranging path: on request, emits a shaped square-wave probe burst onto the speaker sample stream at the 24 kHz `step_in` rate. It pulses `onset_out` on the exact cycle the first burst sample appears, giving the echo analyzer a sample-accurate time zero. After the burst it enforces a silent guard interval so a new probe cannot mask the previous echo.

## Interface
- `HALF_PERIOD`, 3: samples per half-cycle of the square wave (≥1).
- `CYCLES`, 4: full square-wave periods per burst (≥1).
- `AMPLITUDE`, 16000: peak magnitude, 1..32767.
- `RAMP_LOG2`, 2: envelope ramp length RAMP = 2^RAMP_LOG2 samples.
- `GUARD`, 256: silent samples after the burst before `done_out`.
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset, synchronous, active-low.
- `step_in` input 1: one-cycle 24 kHz sample strobe.
- `start_in` input 1: request a burst (level or pulse; sampled each clk).
- `abort_in` input 1: cancel a burst or guard in progress.
- `amp_out` output signed 16: audio sample to speaker mixer.
- `onset_out` output 1: one-cycle pulse with the first burst sample.
- `busy_out` output 1: high from acceptance until return to IDLE.
- `done_out` output 1: one-cycle pulse at normal completion.

## Operation
- N = 2·HALF_PERIOD·CYCLES burst samples, index i = 0..N-1.
- Sign: positive for the first HALF_PERIOD samples, then alternating every HALF_PERIOD samples.
- States:
  - IDLE: `start_in` high → ARMED, `busy_out`=1.
  - ARMED: next `step_in` → EMIT, emit i=0, pulse `onset_out`.
  - EMIT: each `step_in` emits the next i. The `step_in` after i=N-1 sets `amp_out`=0 and → GUARD, guard count 0.
  - GUARD: counts `step_in`. On the GUARD-th strobe → IDLE, `done_out` pulse, `busy_out`=0.
- `start_in` is ignored outside IDLE; no queuing.
- `abort_in` in ARMED, EMIT or GUARD → IDLE next clk, `amp_out`=0, `busy_out`=0, no `done_out`. `abort_in` has priority over `step_in`.
- `abort_in` in IDLE has no effect. `start_in` and `abort_in` together in IDLE: start accepted.
- Magnitude: |s| = (AMPLITUDE·env) >> RAMP_LOG2, where env = min(i+1, RAMP, N-i) when `PROBE_RAMP_EN` is defined. The product is computed at 16+RAMP_LOG2 bits, unsigned, before the shift. The result is negated for negative half-cycles; it never exceeds 32767, so there is no saturation.
- Counters are sized by $clog2 of N, HALF_PERIOD and GUARD, plus one bit. No wrap-around within a burst.

## Timing
- Reset (`rst_in`=0 at a clk edge): state IDLE, `amp_out`=0, `onset_out`=0, `busy_out`=0, `done_out`=0, all counters 0. Reset applies mid-burst with the same values.
- All outputs are registered.
- `amp_out` changes only on the clk edge sampling `step_in`=1, or on abort/reset.
- `onset_out` is high during exactly the clk cycle in which `amp_out` first holds sample i=0.
- Start to onset: at least 1 clk, and the first sample waits for the first `step_in` strictly after acceptance. A `step_in` coincident with `start_in` does not emit.
- `done_out` and the `busy_out` fall happen on the same clk edge. A new `start_in` is accepted on the following clk.
- Total occupancy: N + GUARD strobes after onset.

## Configuration
- `PROBE_RAMP_EN` defined: linear attack/decay envelope per Operation, reducing speaker click splatter.
- Not defined: env = RAMP for all i, so |s| = AMPLITUDE (hard-edged burst), and the multiplier is removed.

## Structure
- Shared package `sos_pkg`: probe state enum (IDLE, ARMED, EMIT, GUARD), sample width constant (16), sample rate constant (24000).
- Sub-module `probe_envelope_gain`: takes i, N and the sign, returns the signed sample, with registered output. It is instantiated only under `PROBE_RAMP_EN`; otherwise a constant ±AMPLITUDE path is used.

## Test plan
All tests use HALF_PERIOD=3, CYCLES=2, AMPLITUDE=8000, RAMP_LOG2=1, GUARD=4, and `step_in` every 10 clk.
- Ramp on, start in IDLE → onset pulse with `amp_out`=4000; then 8000, 8000, −8000×3, 8000×3, −8000, −8000, −4000, then 0. `done_out` comes 4 strobes later.
- Ramp off, same stimulus → `amp_out` is +8000×3, −8000×3, +8000×3, −8000×3, then 0. `busy_out` is high for 16 strobes after onset.
- `start_in` coincident with `step_in` in IDLE → no sample on that strobe. Onset occurs on the next strobe.
- `start_in` re-asserted during EMIT and GUARD → ignored. Exactly one `done_out` is produced; a start on the clk after `done_out` is accepted.
- `abort_in` at sample i=5 → `amp_out`=0 and `busy_out`=0 next clk, no `done_out`. A restart gives a fresh onset at i=0.
- `rst_in` low for 1 clk mid-EMIT → all outputs 0 and IDLE on that edge. Later strobes emit nothing until a new start.
